fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch and PC-sequencing stage of the MIPS core, directly upstream of the main control decoder.
- Holds the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents the fetched instruction, plus its opcode and funct fields, to the decoder.
- Computes the next PC from the decoder's Branch/Jump/JumpReg outputs and the ALU zero flag, and counts retired instructions.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (equals pc)
imem_ack  in  1  memory ack; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  registered current instruction
opcode  out  6  instr[31:26], to decoder
funct  out  6  instr[5:0], to decoder
instr_valid  out  1  instr is valid and executing
exec_done  in  1  datapath finished current instruction; commit next PC
Branch  in  2  from decoder: 01 beq, 10 bne, 00/11 none
Jump  in  1  from decoder: j/jal
JumpReg  in  1  from decoder: jr
zero  in  1  ALU zero flag
rs_data  in  32  register rs value (jr target)
pc  out  32  current PC
pc_plus4  out  32  pc+4, combinational (jal link value)
misaligned_err  out  1  sticky: jr target had nonzero bits [1:0]
instr_count  out  32  retired instruction counter

Behaviour:
- States:
  - S_RESET: one cycle after reset release; imem_req=0; imem_ack ignored.
  - S_FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - S_ISSUE: instr_valid=1; waits for exec_done.
- Transitions:
  - S_RESET→S_FETCH unconditionally.
  - S_FETCH→S_ISSUE on imem_ack; instr<=imem_rdata on the same edge.
  - S_ISSUE→S_FETCH on exec_done; pc<=next_pc and instr_count<=instr_count+1 on the same edge.
- Latency: ack in cycle N gives instr_valid=1 in N+1. exec_done in cycle M gives imem_req=1 with the new address in M+1. Ack-to-ack minimum is 2 cycles.
- exec_done outside S_ISSUE is ignored. imem_ack outside S_FETCH is ignored.
- instr_valid is registered and equals (state==S_ISSUE). Control inputs are sampled only on the exec_done edge.
- next_pc, priority high to low:
  1. JumpReg=1: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, set misaligned_err.
  2. Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. Branch=01 and zero=1, or Branch=10 and zero=0: pc_plus4 + (sign_extend(instr[15:0])<<2).
  4. Otherwise (including Branch=11): pc_plus4.
- Arithmetic is 32-bit and wraps modulo 2^32 (pc=0xFFFFFFFC gives pc_plus4=0). instr_count wraps 0xFFFFFFFF→0.
- X on Branch/Jump/JumpReg when exec_done=0 must not affect state.
- Reset values (asynchronous, immediate on rst_n=0, any state including mid-handshake):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misaligned_err=0, instr_count=0, state=S_RESET.
  - A pending request is abandoned. misaligned_err clears only on reset.

Test Plan:
- Reset/first fetch: RESET_PC=0x00400000, release rst_n → 1 cycle imem_req=0, then imem_req=1, addr=0x00400000. Ack with 0x20080005 → next cycle instr_valid=1, opcode=6'b001000. exec_done with Branch=00 → pc=0x00400004, instr_count=1.
- beq: pc=0x00400010, instr=0x1109FFFC, Branch=01, zero=1, exec_done → pc=0x00400004. Same with zero=0 → pc=0x00400014.
- bne/Branch=11: same instr, Branch=10, zero=0 → 0x00400004; Branch=10, zero=1 → 0x00400014; Branch=11, zero=1 → 0x00400014.
- Jumps and priority:
  - pc=0x00400020, instr=0x08100010, Jump=1 → pc=0x00400040.
  - JumpReg=1, Jump=1, rs_data=0x00400102 → pc=0x00400100, misaligned_err=1 and stays 1 after later commits.
- Slow memory: hold imem_ack=0 for 5 cycles while pulsing exec_done → imem_req=1 and imem_addr constant throughout; pc and instr_count unchanged.
- Reset mid-operation: rst_n=0 during S_ISSUE → instr_valid=0 and pc=RESET_PC immediately. imem_ack=1 in the S_RESET cycle → ignored, instr stays 0. Next cycle imem_req=1.

Source files
------------

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch and PC-sequencing stage. Holds the PC,
//               fetches instructions over a req/ack handshake, presents the
//               instruction (plus opcode/funct) to the decoder, computes the
//               next PC from Branch/Jump/JumpReg/zero and counts retired
//               instructions.
// Ports       : clk, rst_n            - clock, async active-low reset
//               o_imem_req/addr       - fetch request and address (= pc)
//               i_imem_ack/rdata      - fetch acknowledge and instruction word
//               o_instr/opcode/funct  - current instruction and decode fields
//               o_instr_valid         - instruction valid and executing
//               i_exec_done           - commit next PC
//               i_branch/jump/jump_reg/zero/rs_data - next-PC controls
//               o_pc/o_pc_plus4       - current PC and pc+4 (link value)
//               o_misaligned_err      - sticky misaligned jr target flag
//               o_instr_count         - retired instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic [5:0]  o_funct,
    output logic        o_instr_valid,
    input  logic        i_exec_done,
    input  logic [1:0]  i_branch,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    input  logic        i_zero,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_misaligned_err,
    output logic [31:0] o_instr_count
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic        r_misaligned_err;
    logic [31:0] r_instr_count;

    logic        w_fetch_done;
    logic        w_commit;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic        w_br_taken;
    logic [31:0] w_next_pc;
    logic        w_jr_misaligned;

    // Handshake events only count in their own state; everything else ignored.
    assign w_fetch_done = (r_state == S_FETCH) && i_imem_ack;
    assign w_commit     = (r_state == S_ISSUE) && i_exec_done;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_br_off        = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_taken      = ((i_branch == 2'b01) &&  i_zero) ||
                             ((i_branch == 2'b10) && !i_zero);
    assign w_jr_misaligned = i_jump_reg && (i_rs_data[1:0] != 2'b00);

    // Next-PC select: jr beats j beats a taken branch beats sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jump_reg) begin
            w_next_pc = {i_rs_data[31:2], 2'b00};
        end else if (i_jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_br_taken) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET: w_next_state = S_FETCH;
            S_FETCH: if (w_fetch_done) w_next_state = S_ISSUE;
            S_ISSUE: if (w_commit)     w_next_state = S_FETCH;
            default: w_next_state = S_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. imem_req and instr_valid are registered copies
    // of the next state so they switch on the same edge as the FSM.
    // Control inputs are only looked at under w_commit, so X on them in
    // other cycles cannot leak into state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_instr          <= 32'd0;
            r_instr_valid    <= 1'b0;
            r_imem_req       <= 1'b0;
            r_misaligned_err <= 1'b0;
            r_instr_count    <= 32'd0;
        end else begin
            r_imem_req    <= (w_next_state == S_FETCH);
            r_instr_valid <= (w_next_state == S_ISSUE);
            if (w_fetch_done) begin
                r_instr <= i_imem_rdata;
            end
            if (w_commit) begin
                r_pc          <= w_next_pc;
                r_instr_count <= r_instr_count + 32'd1;
                if (w_jr_misaligned) begin
                    r_misaligned_err <= 1'b1;
                end
            end
        end
    end

    assign o_imem_req       = r_imem_req;
    assign o_imem_addr      = r_pc;
    assign o_instr          = r_instr;
    assign o_opcode         = r_instr[31:26];
    assign o_funct          = r_instr[5:0];
    assign o_instr_valid    = r_instr_valid;
    assign o_pc             = r_pc;
    assign o_pc_plus4       = w_pc_plus4;
    assign o_misaligned_err = r_misaligned_err;
    assign o_instr_count    = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. Directed scenarios for
//               reset, branches, jumps, slow memory and wrap-around, then a
//               randomized run checked against a behavioural PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  branch;
    logic        jump;
    logic        jump_reg;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned_err;
    logic [31:0] instr_count;

    fetch_pc_unit #(.RESET_PC(C_RESET_PC)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata),
        .o_instr          (instr),
        .o_opcode         (opcode),
        .o_funct          (funct),
        .o_instr_valid    (instr_valid),
        .i_exec_done      (exec_done),
        .i_branch         (branch),
        .i_jump           (jump),
        .i_jump_reg       (jump_reg),
        .i_zero           (zero),
        .i_rs_data        (rs_data),
        .o_pc             (pc),
        .o_pc_plus4       (pc_plus4),
        .o_misaligned_err (misaligned_err),
        .o_instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive random control noise on inputs that must be ignored this cycle.
    task automatic noise_ctrl();
        branch   = 2'($urandom);
        jump     = 1'($urandom);
        jump_reg = 1'($urandom);
        zero     = 1'($urandom);
        rs_data  = $urandom;
    endtask

    // Entered at a negedge with the DUT in the fetch state.
    task automatic do_fetch(input logic [31:0] word, input int delay);
        for (int d = 0; d < delay; d++) begin
            chk("fetch_wait_req",  {31'd0, imem_req}, 32'd1);
            chk("fetch_wait_addr", imem_addr, m_pc);
            chk("fetch_wait_cnt",  instr_count, m_count);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            exec_done  = 1'($urandom);
            noise_ctrl();
            @(negedge clk);
        end
        chk("fetch_req",  {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_vld",  {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        exec_done  = 1'($urandom);
        noise_ctrl();
        @(negedge clk);
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        m_instr   = word;
        chk("issue_vld",    {31'd0, instr_valid}, 32'd1);
        chk("issue_req",    {31'd0, imem_req}, 32'd0);
        chk("issue_instr",  instr, m_instr);
        chk("issue_opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
        chk("issue_funct",  {26'd0, funct},  {26'd0, m_instr[5:0]});
        chk("issue_pc4",    pc_plus4, m_pc + 32'd4);
    endtask

    // Entered at a negedge with the DUT in the issue state.
    task automatic do_exec(input logic [1:0] br, input logic j, input logic jr,
                           input logic z, input logic [31:0] rs, input int hold);
        logic [31:0] p4;
        int          off;
        for (int d = 0; d < hold; d++) begin
            exec_done  = 1'b0;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            noise_ctrl();
            @(negedge clk);
            chk("hold_vld",   {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, m_instr);
            chk("hold_pc",    pc, m_pc);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        branch    = br;
        jump      = j;
        jump_reg  = jr;
        zero      = z;
        rs_data   = rs;
        // Reference next PC from the architectural rules
        p4 = m_pc + 32'd4;
        if (jr) begin
            if (rs % 4 != 0) m_err = 1'b1;
            m_pc = rs - (rs % 4);
        end else if (j) begin
            m_pc = (p4 & 32'hF000_0000) + (m_instr % (1 << 26)) * 4;
        end else if ((br == 2'b01 && z) || (br == 2'b10 && !z)) begin
            off  = int'($signed(m_instr[15:0]));
            m_pc = p4 + 32'(off * 4);
        end else begin
            m_pc = p4;
        end
        m_count = m_count + 32'd1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("commit_pc",   pc, m_pc);
        chk("commit_req",  {31'd0, imem_req}, 32'd1);
        chk("commit_addr", imem_addr, m_pc);
        chk("commit_vld",  {31'd0, instr_valid}, 32'd0);
        chk("commit_cnt",  instr_count, m_count);
        chk("commit_err",  {31'd0, misaligned_err}, {31'd0, m_err});
    endtask

    task automatic goto_pc(input logic [31:0] target);
        do_fetch($urandom, 0);
        do_exec(2'b00, 1'b0, 1'b1, 1'b0, target, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exec_done  = 1'b0;
        branch     = 2'b00;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        zero       = 1'b0;
        rs_data    = 32'd0;
        m_pc       = C_RESET_PC;
        m_instr    = 32'd0;
        m_count    = 32'd0;
        m_err      = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_pc",    pc, C_RESET_PC);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_vld",   {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_cnt",   instr_count, 32'd0);
        chk("rst_err",   {31'd0, misaligned_err}, 32'd0);

        // Release: one cycle in the reset state, ack there is ignored.
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("first_req",   {31'd0, imem_req}, 32'd1);
        chk("first_addr",  imem_addr, 32'h0040_0000);
        chk("first_instr", instr, 32'd0);

        // First instruction: addi, sequential commit
        do_fetch(32'h2008_0005, 0);
        chk("tp_opcode", {26'd0, opcode}, 32'h0000_0008);
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1);
        chk("tp_pc1",  pc, 32'h0040_0004);
        chk("tp_cnt1", instr_count, 32'd1);

        // beq taken / not taken
        goto_pc(32'h0040_0010);
        do_fetch(32'h1109_FFFC, 1);
        do_exec(2'b01, 1'b0, 1'b0, 1'b1, 32'd0, 0);
        chk("tp_beq_t", pc, 32'h0040_0004);
        goto_pc(32'h0040_0010);
        do_fetch(32'h1109_FFFC, 0);
        do_exec(2'b01, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("tp_beq_nt", pc, 32'h0040_0014);

        // bne taken / not taken, Branch=11 never taken
        goto_pc(32'h0040_0010);
        do_fetch(32'h1109_FFFC, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("tp_bne_t", pc, 32'h0040_0004);
        goto_pc(32'h0040_0010);
        do_fetch(32'h1109_FFFC, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b1, 32'd0, 0);
        chk("tp_bne_nt", pc, 32'h0040_0014);
        goto_pc(32'h0040_0010);
        do_fetch(32'h1109_FFFC, 0);
        do_exec(2'b11, 1'b0, 1'b0, 1'b1, 32'd0, 0);
        chk("tp_br11", pc, 32'h0040_0014);

        // j, then jr beating j with a misaligned target
        goto_pc(32'h0040_0020);
        do_fetch(32'h0810_0010, 0);
        do_exec(2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 0);
        chk("tp_j", pc, 32'h0040_0040);
        do_fetch(32'h0810_0010, 0);
        do_exec(2'b01, 1'b1, 1'b1, 1'b1, 32'h0040_0102, 0);
        chk("tp_jr",     pc, 32'h0040_0100);
        chk("tp_jr_err", {31'd0, misaligned_err}, 32'd1);

        // Slow memory with exec_done noise while waiting
        do_fetch(32'h0000_0020, 5);
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 2);
        chk("tp_err_sticky", {31'd0, misaligned_err}, 32'd1);

        // PC wrap-around
        goto_pc(32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'd0);
        do_fetch(32'h0000_0000, 0);
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("wrap_pc", pc, 32'd0);

        // Randomized run against the model
        for (int it = 0; it < 60; it++) begin
            logic [1:0] rb;
            logic       rj;
            logic       rjr;
            rb  = 2'($urandom);
            rj  = ($urandom_range(0, 3) == 0);
            rjr = ($urandom_range(0, 5) == 0);
            do_fetch($urandom, $urandom_range(0, 4));
            do_exec(rb, rj, rjr, 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        // Asynchronous reset in the issue state
        do_fetch(32'h1234_5678, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",   {31'd0, instr_valid}, 32'd0);
        chk("arst_pc",    pc, C_RESET_PC);
        chk("arst_req",   {31'd0, imem_req}, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_cnt",   instr_count, 32'd0);
        chk("arst_err",   {31'd0, misaligned_err}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("arst_ack_ign", instr, 32'd0);
        chk("arst_req2",    {31'd0, imem_req}, 32'd1);
        chk("arst_addr2",   imem_addr, C_RESET_PC);
        chk("arst_vld2",    {31'd0, instr_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
